data_memory_ctrl: RTL and testbench

- Parametrised successor to the single-port word data memory for the RISC-V single-cycle/multi-cycle core.
- Adds RISC-V sized loads and stores (byte, half, word, signed and unsigned), byte-lane write enables, misalignment and range checking, and a configurable read latency.
- Uses a valid/ready request channel and a one-cycle response pulse.
- Sits between the core's load/store unit and the on-chip RAM array; the array is internal to this block.

---
 rtl/data_memory_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// data_memory_ctrl
//
// Word-organised data memory for the RISC-V core's load/store unit. Handles
// RISC-V sized loads and stores (byte, half, word; signed and unsigned
// loads), byte-lane write enables, alignment, range and funct3 checking, and
// a configurable load latency. The RAM array is internal to this block.
//
// Parameters:
//   ADDR_W       request address width in bits
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   RD_LATENCY   cycles from load accept to load response (1..4)
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   rst         synchronous reset, active-high
//   req_valid   request present
//   req_ready   request can be accepted this cycle
//   req_we      1 = store, 0 = load
//   req_funct3  RISC-V funct3 (size and sign)
//   req_addr    byte address
//   req_wdata   store data, right-aligned
//   rsp_valid   one-cycle response pulse
//   rsp_rdata   load result extended to 32 bits; 0 for stores and errors
//   rsp_err     misaligned, out of range or illegal funct3 (with rsp_valid)
// ---------------------------------------------------------------------------
module data_memory_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LATENCY  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int         IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [2:0] LAT_M1 = 3'(RD_LATENCY - 1);

    // funct3 encodings shared by loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [2:0]  counter;
    logic [31:0] pipe_rdata;
    logic        pipe_err;

    logic [31:0] mem [DEPTH_WORDS];

    // -----------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------
    logic              accept;
    logic              short_path;
    logic [ADDR_W-3:0] word_idx;
    logic [IDX_W-1:0]  ram_idx;
    logic [1:0]        lane;

    logic        illegal_f3;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic [3:0]  byte_en;
    logic [31:0] wdata_lanes;
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;

    assign req_ready = !rst && (state == IDLE || state == RESP);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == RESP);

    assign word_idx = req_addr[ADDR_W-1:2];
    assign ram_idx  = word_idx[IDX_W-1:0];
    assign lane     = req_addr[1:0];

    // Stores always answer after one cycle; loads follow RD_LATENCY.
    assign short_path = req_we || (RD_LATENCY == 1);

    // Any index bit at or above IDX_W is out of range; there is no wrap.
    assign out_of_range = (word_idx >> IDX_W) != '0;

    // NOTE: every signal assigned in always_comb gets a default first so a
    // missing case arm can never infer a latch.
    always_comb begin
        illegal_f3  = 1'b0;
        misaligned  = 1'b0;
        byte_en     = 4'b0000;
        wdata_lanes = req_wdata;

        if (req_we) begin
            illegal_f3 = !(req_funct3 == F3_B || req_funct3 == F3_H ||
                           req_funct3 == F3_W);
        end else begin
            illegal_f3 = !(req_funct3 == F3_B  || req_funct3 == F3_H  ||
                           req_funct3 == F3_W  || req_funct3 == F3_BU ||
                           req_funct3 == F3_HU);
        end

        // funct3[1:0] encodes the access size for every legal code.
        case (req_funct3[1:0])
            2'b01:   misaligned = lane[0];
            2'b10:   misaligned = (lane != 2'b00);
            default: misaligned = 1'b0;
        endcase

        // Store data is replicated across lanes so the byte enables alone
        // select which copy lands in the RAM.
        case (req_funct3[1:0])
            2'b00: begin
                wdata_lanes = {4{req_wdata[7:0]}};
                byte_en     = 4'b0001 << lane;
            end
            2'b01: begin
                wdata_lanes = {2{req_wdata[15:0]}};
                byte_en     = lane[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                wdata_lanes = req_wdata;
                byte_en     = 4'b1111;
            end
            default: begin
                wdata_lanes = req_wdata;
                byte_en     = 4'b0000;
            end
        endcase
    end

    assign req_err = illegal_f3 || misaligned || out_of_range;

    // Load extraction from the addressed word.
    assign rd_word = mem[ram_idx];
    assign rd_byte = rd_word[{lane, 3'b000} +: 8];
    assign rd_half = rd_word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        load_data = 32'h0;
        if (!req_we && !req_err) begin
            case (req_funct3)
                F3_B:    load_data = {{24{rd_byte[7]}}, rd_byte};
                F3_H:    load_data = {{16{rd_half[15]}}, rd_half};
                F3_W:    load_data = rd_word;
                F3_BU:   load_data = {24'h0, rd_byte};
                F3_HU:   load_data = {16'h0, rd_half};
                default: load_data = 32'h0;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // RAM array
    // -----------------------------------------------------------------------
    // NOTE: the RAM has no reset branch; clearing a memory array would turn
    // it into a large register file, and stored data must survive rst.
    always_ff @(posedge clk) begin
        if (accept && req_we && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[ram_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = short_path ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (counter == 3'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                // A new request may be taken during the response cycle.
                if (accept) begin
                    state_next = short_path ? RESP : WAIT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Control FSM: state register, latency counter and response registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            counter    <= 3'd0;
            pipe_rdata <= 32'h0;
            pipe_err   <= 1'b0;
            rsp_rdata  <= 32'h0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                if (short_path) begin
                    rsp_rdata <= load_data;
                    rsp_err   <= req_err;
                end else begin
                    pipe_rdata <= load_data;
                    pipe_err   <= req_err;
                    counter    <= LAT_M1;
                end
            end else if (state == WAIT) begin
                counter <= counter - 3'd1;
                // The response registers change only when entering RESP so
                // they hold their last values in between.
                if (counter == 3'd1) begin
                    rsp_rdata <= pipe_rdata;
                    rsp_err   <= pipe_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_memory_ctrl
//
// Self-checking bench for data_memory_ctrl. Two instances share the clock
// and reset: u_lat1 with RD_LATENCY=1 and u_lat3 with RD_LATENCY=3. Expected
// responses are queued when a request is driven and popped when the DUT
// answers.
// ---------------------------------------------------------------------------
module tb_data_memory_ctrl;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;
    localparam logic [2:0] F_X3 = 3'b011;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      req_valid = '0;
    logic [1:0]      req_ready;
    logic [1:0]      req_we = '0;
    logic [1:0][2:0] req_funct3 = '0;
    logic [1:0][31:0] req_addr = '0;
    logic [1:0][31:0] req_wdata = '0;
    logic [1:0]      rsp_valid;
    logic [1:0][31:0] rsp_rdata;
    logic [1:0]      rsp_err;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    data_memory_ctrl #(.ADDR_W(32), .DEPTH_WORDS(1024), .RD_LATENCY(1)) u_lat1 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid[0]),
        .req_ready  (req_ready[0]),
        .req_we     (req_we[0]),
        .req_funct3 (req_funct3[0]),
        .req_addr   (req_addr[0]),
        .req_wdata  (req_wdata[0]),
        .rsp_valid  (rsp_valid[0]),
        .rsp_rdata  (rsp_rdata[0]),
        .rsp_err    (rsp_err[0])
    );

    data_memory_ctrl #(.ADDR_W(32), .DEPTH_WORDS(1024), .RD_LATENCY(3)) u_lat3 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid[1]),
        .req_ready  (req_ready[1]),
        .req_we     (req_we[1]),
        .req_funct3 (req_funct3[1]),
        .req_addr   (req_addr[1]),
        .req_wdata  (req_wdata[1]),
        .rsp_valid  (rsp_valid[1]),
        .rsp_rdata  (rsp_rdata[1]),
        .rsp_err    (rsp_err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expected response and compare it with the DUT outputs.
    task automatic pop_and_check(input int d, input string tag);
        exp_t e;
        check({tag, " sb_not_empty"}, 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, " rdata"}, rsp_rdata[d], e.rdata);
            check({tag, " err"}, 32'(rsp_err[d]), 32'(e.err));
        end
    endtask

    // One request on instance d, then wait (bounded) for its response and
    // check data, error flag, latency and the single-cycle pulse.
    task automatic do_req(input int d, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input string tag);
        int n;
        @(negedge clk);
        req_valid[d]  = 1'b1;
        req_we[d]     = we;
        req_funct3[d] = f3;
        req_addr[d]   = addr;
        req_wdata[d]  = wdata;
        n = 0;
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " ready"}, 32'(req_ready[d]), 32'd1);
        if (req_ready[d]) begin
            sb_q.push_back('{rdata: exp_rdata, err: exp_err});
            @(posedge clk);
            @(negedge clk);
            req_valid[d] = 1'b0;
            n = 1;
            while (!rsp_valid[d] && n < 20) begin
                @(negedge clk);
                n++;
            end
            check({tag, " rsp_valid"}, 32'(rsp_valid[d]), 32'd1);
            check({tag, " latency"}, 32'(n), 32'(exp_lat));
            if (rsp_valid[d]) pop_and_check(d, tag);
            @(negedge clk);
            check({tag, " pulse_end"}, 32'(rsp_valid[d]), 32'd0);
        end else begin
            req_valid[d] = 1'b0;
        end
    endtask

    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_data [3];
    int          acc;

    initial begin
        // ---------------- reset state ----------------
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst ready", 32'(req_ready[d]), 32'd0);
            check("rst rsp_valid", 32'(rsp_valid[d]), 32'd0);
            check("rst rsp_rdata", rsp_rdata[d], 32'h0);
            check("rst rsp_err", 32'(rsp_err[d]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_rst ready0", 32'(req_ready[0]), 32'd1);
        check("post_rst ready1", 32'(req_ready[1]), 32'd1);

        // ---------------- latency 1: stores and sized loads ----------------
        do_req(0, 1'b1, F_W,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1, "sw_10");
        do_req(0, 1'b0, F_W,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1, "lw_10");
        do_req(0, 1'b1, F_B,  32'h11, 32'h000000AA, 32'h0,        1'b0, 1, "sb_11");
        do_req(0, 1'b0, F_W,  32'h10, 32'h0,        32'hDEADAAEF, 1'b0, 1, "lw_10_b");
        do_req(0, 1'b0, F_B,  32'h11, 32'h0,        32'hFFFFFFAA, 1'b0, 1, "lb_11");
        do_req(0, 1'b0, F_BU, 32'h11, 32'h0,        32'h000000AA, 1'b0, 1, "lbu_11");
        do_req(0, 1'b0, F_H,  32'h12, 32'h0,        32'hFFFFDEAD, 1'b0, 1, "lh_12");
        do_req(0, 1'b0, F_HU, 32'h12, 32'h0,        32'h0000DEAD, 1'b0, 1, "lhu_12");
        do_req(0, 1'b1, F_W,  32'h14, 32'h0,        32'h0,        1'b0, 1, "sw_14");
        do_req(0, 1'b1, F_H,  32'h16, 32'hFFFF1234, 32'h0,        1'b0, 1, "sh_16");
        do_req(0, 1'b0, F_W,  32'h14, 32'h0,        32'h12340000, 1'b0, 1, "lw_14");
        do_req(0, 1'b0, F_H,  32'h14, 32'h0,        32'h00000000, 1'b0, 1, "lh_14");

        // ---------------- boundaries and error cases ----------------
        do_req(0, 1'b1, F_W,  32'h0,    32'h55555555, 32'h0,        1'b0, 1, "sw_0");
        do_req(0, 1'b1, F_W,  32'hFFC,  32'hA5A5A5A5, 32'h0,        1'b0, 1, "sw_last");
        do_req(0, 1'b0, F_W,  32'hFFC,  32'h0,        32'hA5A5A5A5, 1'b0, 1, "lw_last");
        do_req(0, 1'b0, F_W,  32'h12,   32'h0,        32'h0,        1'b1, 1, "lw_misal");
        do_req(0, 1'b1, F_H,  32'h13,   32'h0000FFFF, 32'h0,        1'b1, 1, "sh_misal");
        do_req(0, 1'b0, F_X3, 32'h10,   32'h0,        32'h0,        1'b1, 1, "ld_f3_011");
        do_req(0, 1'b1, F_BU, 32'h10,   32'h0,        32'h0,        1'b1, 1, "st_f3_100");
        do_req(0, 1'b0, F_W,  32'h1000, 32'h0,        32'h0,        1'b1, 1, "lw_range");
        do_req(0, 1'b1, F_W,  32'h1000, 32'h77777777, 32'h0,        1'b1, 1, "sw_range");
        do_req(0, 1'b0, F_W,  32'h0,    32'h0,        32'h55555555, 1'b0, 1, "lw_0_nowrap");
        do_req(0, 1'b0, F_W,  32'h10,   32'h0,        32'hDEADAAEF, 1'b0, 1, "lw_10_intact");

        // ---------------- latency 3 ----------------
        do_req(1, 1'b1, F_W,  32'h10, 32'hCAFEF00D, 32'h0,        1'b0, 1, "l3_sw_10");
        do_req(1, 1'b1, F_W,  32'h14, 32'h01234567, 32'h0,        1'b0, 1, "l3_sw_14");
        do_req(1, 1'b1, F_W,  32'h18, 32'h89ABCDEF, 32'h0,        1'b0, 1, "l3_sw_18");
        do_req(1, 1'b0, F_HU, 32'h1A, 32'h0,        32'h000089AB, 1'b0, 3, "l3_lhu_1a");
        do_req(1, 1'b0, F_H,  32'h11, 32'h0,        32'h0,        1'b1, 3, "l3_lh_misal");

        // Back-to-back loads with req_valid held high.
        b2b_addr[0] = 32'h10; b2b_data[0] = 32'hCAFEF00D;
        b2b_addr[1] = 32'h14; b2b_data[1] = 32'h01234567;
        b2b_addr[2] = 32'h18; b2b_data[2] = 32'h89ABCDEF;
        acc = 0;
        @(negedge clk);
        req_valid[1]  = 1'b1;
        req_we[1]     = 1'b0;
        req_funct3[1] = F_W;
        req_addr[1]   = b2b_addr[0];
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) begin
                @(negedge clk);
                if (acc < 3) req_addr[1] = b2b_addr[acc];
            end
            check($sformatf("b2b ready k%0d", k), 32'(req_ready[1]), 32'((k % 3) == 0));
            check($sformatf("b2b rsp_valid k%0d", k), 32'(rsp_valid[1]),
                  32'(k > 0 && (k % 3) == 0));
            if (rsp_valid[1]) pop_and_check(1, $sformatf("b2b rsp k%0d", k));
            if (k == 9) begin
                req_valid[1] = 1'b0;
            end else if (req_ready[1] && acc < 3) begin
                sb_q.push_back('{rdata: b2b_data[acc], err: 1'b0});
                acc++;
            end
        end
        @(negedge clk);
        check("b2b idle rsp_valid", 32'(rsp_valid[1]), 32'd0);
        check("b2b idle ready", 32'(req_ready[1]), 32'd1);
        check("b2b accepts", 32'(acc), 32'd3);

        // ---------------- reset during WAIT ----------------
        @(negedge clk);
        req_valid[1]  = 1'b1;
        req_we[1]     = 1'b0;
        req_funct3[1] = F_W;
        req_addr[1]   = 32'h14;
        check("rw accept ready", 32'(req_ready[1]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        check("rw wait ready", 32'(req_ready[1]), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rw in_rst ready", 32'(req_ready[1]), 32'd0);
        check("rw in_rst rsp_valid", 32'(rsp_valid[1]), 32'd0);
        check("rw in_rst rdata", rsp_rdata[1], 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("rw dropped k%0d", k), 32'(rsp_valid[1]), 32'd0);
            if (k == 0) check("rw release ready", 32'(req_ready[1]), 32'd1);
        end
        do_req(1, 1'b0, F_W, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0, 3, "l3_lw_after_rst");
        do_req(0, 1'b0, F_W, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0, 1, "l1_lw_after_rst");

        // ---------------- request during reset ----------------
        do_req(0, 1'b1, F_W, 32'h20, 32'h11112222, 32'h0, 1'b0, 1, "sw_20");
        @(negedge clk);
        rst           = 1'b1;
        req_valid[0]  = 1'b1;
        req_we[0]     = 1'b1;
        req_funct3[0] = F_W;
        req_addr[0]   = 32'h20;
        req_wdata[0]  = 32'h12345678;
        #1;
        check("rv ready_in_rst", 32'(req_ready[0]), 32'd0);
        @(negedge clk);
        check("rv ready_in_rst2", 32'(req_ready[0]), 32'd0);
        check("rv rsp_valid", 32'(rsp_valid[0]), 32'd0);
        req_valid[0] = 1'b0;
        rst          = 1'b0;
        @(negedge clk);
        check("rv no_rsp", 32'(rsp_valid[0]), 32'd0);
        do_req(0, 1'b0, F_W, 32'h20, 32'h0, 32'h11112222, 1'b0, 1, "lw_20_old");

        check("sb drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
